pdm_modulator: RTL and testbench

Converts a stream of signed PCM samples into a 1-bit PDM bitstream plus bit clock, using an error-feedback sigma-delta modulator. It is the transmit counterpart of the PDM decimation chain (CIC → halfband → FIR). It is used to drive a real PDM sink and to generate closed-loop stimulus for the decimator in simulation. Samples enter through a small FIFO with valid/ready handshake, and each sample is held for OSR PDM bits.

---
 rtl/pdm_modulator.sv | 201 ++++++++++++++++++++
 tb/tb_pdm_modulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator.sv
// PCM-to-PDM sigma-delta modulator with input sample FIFO and PDM bit clock.
// Define PDM_ORDER2_EN for a second-order saturating loop; first order otherwise.
//
// state | meaning
// IDLE  | clocks stopped, outputs low, integrators cleared, FIFO retained
// PRIME | bit clock running, modulator fed zero until the first sample is popped
// RUN   | one FIFO sample per OSR bits; an empty FIFO at a boundary repeats the held sample
module pdm_modulator #(
  parameter int DATA_W     = 16,
  parameter int OSR        = 64,
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_W-1:0]      s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          enable,
  output logic                          pdm_clk,
  output logic                          pdm_out,
  output logic                          pdm_strobe,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);
  localparam int HALF  = CLK_DIV / 2;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic pdm_clk_q, pdm_clk_d, pdm_out_q, pdm_out_d, strobe_q, underrun_q, underrun_d;

  logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q, count_d;
  logic signed [DATA_W-1:0] fifo_head, x;
  logic push, pop, emit, set_underrun, tick, boundary, fifo_empty, y;

  assign s_ready    = (count_q != LVL_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign fifo_level = count_q;
  assign pdm_clk    = pdm_clk_q;
  assign pdm_out    = pdm_out_q;
  assign pdm_strobe = strobe_q;
  assign underrun   = underrun_q;

  assign tick     = (state_q != IDLE) && (div_cnt_q == DIV_W'(HALF));
  assign boundary = tick && (bit_cnt_q == '0);

  // enable is only honoured at a frame boundary, so the last frame always completes
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    emit         = 1'b0;
    set_underrun = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = PRIME;
      PRIME: if (tick) begin
        if (boundary && !enable) begin
          state_d = IDLE;
        end else begin
          emit = 1'b1;
          if (boundary && !fifo_empty) begin
            pop     = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: if (tick) begin
        if (boundary && !enable) begin
          state_d = IDLE;
        end else begin
          emit = 1'b1;
          if (boundary) begin
            if (!fifo_empty) pop = 1'b1;
            else             set_underrun = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_cnt_d  = '0;
    bit_cnt_d  = '0;
    if (state_q != IDLE && state_d != IDLE) begin
      div_cnt_d = (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
      bit_cnt_d = bit_cnt_q;
      if (emit) bit_cnt_d = (bit_cnt_q == BIT_W'(OSR - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
    end
    hold_d     = pop ? fifo_head : hold_q;
    x          = pop ? fifo_head : ((state_q == RUN) ? hold_q : '0);
    pdm_clk_d  = (state_q != IDLE) && (div_cnt_q < DIV_W'(HALF));
    pdm_out_d  = (state_q == IDLE || state_d == IDLE) ? 1'b0 : (emit ? y : pdm_out_q);
    underrun_d = underrun_q | set_underrun;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + LVL_W'(1);
    else if (!push && pop) count_d = count_q - LVL_W'(1);
  end

`ifdef PDM_ORDER2_EN
  localparam int ACC_W = DATA_W + 4;
  localparam int SUM_W = DATA_W + 6;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(ACC_W-1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(ACC_W-1)));
  localparam logic signed [SUM_W-1:0] FB_POS  = SUM_W'(2**(DATA_W-1));

  logic signed [ACC_W-1:0] acc1_q, acc1_d, acc2_q, acc2_d, acc1_nx, acc2_nx;
  logic signed [SUM_W-1:0] fb, sum1, sum2;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[ACC_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  assign y = ~acc2_q[ACC_W-1];

  always_comb begin
    fb      = y ? FB_POS : -FB_POS;
    sum1    = SUM_W'(acc1_q) + SUM_W'(x) - fb;
    acc1_nx = sat(sum1);
    sum2    = SUM_W'(acc2_q) + SUM_W'(acc1_nx) - fb;
    acc2_nx = sat(sum2);
    acc1_d  = (state_q == IDLE) ? '0 : (emit ? acc1_nx : acc1_q);
    acc2_d  = (state_q == IDLE) ? '0 : (emit ? acc2_nx : acc2_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc1_q <= '0;
      acc2_q <= '0;
    end else begin
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
    end
  end
`else
  localparam int ACC_W = DATA_W + 2;
  localparam logic signed [ACC_W-1:0] FB_POS = ACC_W'(2**(DATA_W-1));

  logic signed [ACC_W-1:0] acc_q, acc_d, fb;

  assign y = ~acc_q[ACC_W-1];

  // two guard bits keep acc within [-2^DATA_W, 2^DATA_W) without saturation
  always_comb begin
    fb    = y ? FB_POS : -FB_POS;
    acc_d = (state_q == IDLE) ? '0 : (emit ? acc_q + ACC_W'(x) - fb : acc_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      pdm_clk_q  <= 1'b0;
      pdm_out_q  <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      pdm_clk_q  <= pdm_clk_d;
      pdm_out_q  <= pdm_out_d;
      strobe_q   <= emit;
      underrun_q <= underrun_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Bench for pdm_modulator: per-frame scoreboard of expected PDM bit patterns/densities.
module tb_pdm_modulator;
  localparam int DATA_W = 16, OSR = 64, CLK_DIV = 8, FIFO_DEPTH = 4;
  localparam logic [63:0] ALT  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] ONE1 = 64'h0000_0000_0000_0001;

  logic clk = 1'b0, rst = 1'b0, s_valid = 1'b0, enable = 1'b0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic s_ready, pdm_clk, pdm_out, pdm_strobe, underrun;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  pdm_modulator #(.DATA_W(DATA_W), .OSR(OSR), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .enable(enable), .pdm_clk(pdm_clk), .pdm_out(pdm_out), .pdm_strobe(pdm_strobe),
    .underrun(underrun), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          exact;
    logic [63:0] pat;
    int          lo;
    int          hi;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0, total_strobes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic add_exp(input string name, input bit exact, input logic [63:0] pat,
                         input int lo, input int hi);
    exp_t e;
    e.name = name; e.exact = exact; e.pat = pat; e.lo = lo; e.hi = hi;
    exp_q.push_back(e);
  endtask

  // monitor: collects OSR bits per frame on each strobe, then scores against the queue
  initial begin
    logic [63:0] bits;
    int fbit, gap, hi_cnt, ones;
    bit timing_ok;
    exp_t e;
    bits = '0; fbit = 0; gap = 0; hi_cnt = 0; timing_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        fbit = 0; gap = 0; hi_cnt = 0; timing_ok = 1'b1;
      end else begin
        gap++;
        if (pdm_clk) hi_cnt++;
        if (pdm_strobe) begin
          total_strobes++;
          if (fbit > 0 && (gap != CLK_DIV || hi_cnt != CLK_DIV / 2 || pdm_clk !== 1'b0))
            timing_ok = 1'b0;
          bits[fbit] = pdm_out;
          gap = 0; hi_cnt = 0;
          if (fbit == OSR - 1) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_frame: got frame 0x%0h, expected no frame", bits);
            end else begin
              e = exp_q.pop_front();
              ones = $countones(bits);
              if (e.exact) begin
                check({e.name, "_bits"}, bits, e.pat);
              end else begin
                n_tests++;
                if (ones < e.lo || ones > e.hi) begin
                  n_fail++;
                  $display("FAIL %s_ones: got %0d, expected %0d..%0d", e.name, ones, e.lo, e.hi);
                end
              end
              check({e.name, "_timing"}, 64'(timing_ok), 64'd1);
            end
            fbit = 0; timing_ok = 1'b1;
          end else begin
            fbit++;
          end
        end
      end
    end
  end

  task automatic wait_strobes(input int target, input string name);
    int c = 0;
    while (total_strobes < target && c < 20000) begin @(negedge clk); #1; c++; end
    if (total_strobes < target) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d strobes, expected %0d", name, total_strobes, target);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] v, input string name);
    int c = 0;
    s_data = v; s_valid = 1'b1;
    while (!s_ready && c < 5000) begin @(negedge clk); #1; c++; end
    if (!s_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s_push_timeout: got s_ready 0, expected 1", name);
    end
    @(negedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle_check(input string name);
    int s0;
    bit saw_hi = 1'b0;
    repeat (2 * CLK_DIV) begin @(negedge clk); #1; end
    s0 = total_strobes;
    repeat (100) begin @(negedge clk); #1; if (pdm_clk) saw_hi = 1'b1; end
    check({name, "_idle_strobes"}, 64'(total_strobes - s0), 64'd0);
    check({name, "_idle_pdm_clk"}, 64'(saw_hi), 64'd0);
  endtask

  initial begin
    int base;
    // reset held with random inputs
    repeat (5) begin
      @(negedge clk); #1;
      s_valid = 1'($urandom_range(0, 1)); s_data = DATA_W'($urandom); enable = 1'($urandom_range(0, 1));
    end
    check("rst_pdm_out", 64'(pdm_out), 64'd0);
    check("rst_pdm_clk", 64'(pdm_clk), 64'd0);
    check("rst_strobe", 64'(pdm_strobe), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    s_valid = 1'b0; enable = 1'b0;
    @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); #1;

    // fill with enable low: fifth push refused
    for (int i = 0; i < 5; i++) begin
      s_data = '0; s_valid = 1'b1;
      check($sformatf("fill_s_ready_%0d", i), 64'(s_ready), (i < 4) ? 64'd1 : 64'd0);
      @(negedge clk); #1;
      s_valid = 1'b0;
      check($sformatf("fill_level_%0d", i), 64'(fifo_level), (i < 4) ? 64'(i + 1) : 64'd4);
    end

    // run: 4x zero, 3x 16384, 2x -32768, then underrun frame, enable dropped at bit 10
    base = total_strobes;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) add_exp("zero", 1'b1, ALT, 0, 0);
    for (int i = 0; i < 3; i++) begin add_exp("q16384", 1'b0, '0, 47, 49); push(16'sd16384, "q16384"); end
    add_exp("neg_first", 1'b0, '0, 1, 1);
    push(16'h8000, "neg1");
    add_exp("neg", 1'b0, '0, 0, 0);
    push(16'h8000, "neg2");
    add_exp("underrun_hold", 1'b0, '0, 0, 0);
    wait_strobes(base + OSR * 8 + 5, "pre_underrun");
    check("underrun_before", 64'(underrun), 64'd0);
    wait_strobes(base + OSR * 9 + 1, "underrun");
    check("underrun_set", 64'(underrun), 64'd1);
    wait_strobes(base + OSR * 9 + 10, "drop_point");
    enable = 1'b0;
    wait_strobes(base + OSR * 10, "tail");
    idle_check("run");
    check("tail_bits", 64'(total_strobes - (base + OSR * 9 + 10)), 64'd54);
    check("run_level_end", 64'(fifo_level), 64'd0);

    // PRIME with empty FIFO, then reset mid-frame
    base = total_strobes;
    enable = 1'b1;
    add_exp("prime_alt", 1'b1, ALT, 0, 0);
    wait_strobes(base + OSR + 20, "prime");
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_pdm_out", 64'(pdm_out), 64'd0);
    check("midrst_pdm_clk", 64'(pdm_clk), 64'd0);
    check("midrst_strobe", 64'(pdm_strobe), 64'd0);
    check("midrst_underrun", 64'(underrun), 64'd0);
    check("midrst_level", 64'(fifo_level), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1; rst = 1'b1;
    idle_check("after_rst");

    // single sample: underrun repeats it; a later sample lands on the next frame's first bit
    base = total_strobes;
    push(16'sd16384, "single");
    enable = 1'b1;
    add_exp("single", 1'b0, '0, 47, 49);
    add_exp("single_hold", 1'b0, '0, 47, 49);
    wait_strobes(base + 1, "single_start");
    check("single_underrun0", 64'(underrun), 64'd0);
    wait_strobes(base + OSR + 1, "single_hold");
    check("single_underrun1", 64'(underrun), 64'd1);
    wait_strobes(base + OSR + 5, "latency_push");
    add_exp("latency", 1'b1, ONE1, 0, 0);
    push(16'h8000, "latency");
    wait_strobes(base + 2 * OSR + 5, "latency_frame");
    enable = 1'b0;
    wait_strobes(base + 3 * OSR, "single_end");
    idle_check("single");

    check("pending_frames", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
